add2_accum: RTL and testbench

Sequential accumulator directly downstream of the 2-bit adder. It captures each `{cout, sum}` result under a valid/ready handshake and sums N results into a saturating register. When the run completes, it presents the total on an output handshake. It converts the adder's per-operation combinational output into a registered, multi-sample total for the next stage.

---
 rtl/add2_accum_pkg.sv | 28 ++
 rtl/add2_accum.sv | 99 +++++++++
 tb/tb_add2_accum.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/add2_accum_pkg.sv
// Shared definitions for the 2-bit-adder result accumulator:
// FSM state encoding and the counter-width helper.
package add2_accum_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] ACC_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        ACC  = ACC_ENC,
        DONE = DONE_ENC
    } state_e;

    // Ceiling log2. The caller passes N_SAMPLES+1 (>= 2), so the result is >= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/add2_accum.sv
// Accumulates N_SAMPLES {cout, sum} adder results into a saturating total
// and presents that total on a valid/ready output handshake.
module add2_accum
    import add2_accum_pkg::*;
#(
    parameter  int N_SAMPLES = 8,
    parameter  int ACC_W     = 8,
    localparam int CNT_W     = clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [1:0]       sum,
    input  logic             cout,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W:0]   sum_ext;

    // One extra bit catches the carry that signals saturation.
    assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'({cout, sum});

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    if (sum_ext[ACC_W]) begin
                        acc_d = ACC_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags decode from state alone, keeping inputs off every output path.
    assign in_ready   = (state_q == ACC);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign acc_out    = acc_q;
    assign ovf        = ovf_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_add2_accum.sv
// Self-checking bench for add2_accum: an 8-bit and a 4-bit accumulator share
// stimulus and are checked against an unbounded-integer reference model.
module tb_add2_accum;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [1:0] sum;
    logic       cout;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_ovf, a_busy;
    logic [7:0] a_acc;
    logic [3:0] a_cnt;
    logic       b_in_ready, b_out_valid, b_ovf, b_busy;
    logic [3:0] b_acc;
    logic [3:0] b_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: phase 0 idle, 1 accumulating, 2 done; total is never clipped.
    int          m_phase;
    int          m_total;
    int          m_cnt;
    logic [27:0] exp_vec;
    wire  [27:0] dut_vec = {a_out_valid, a_in_ready, a_busy, a_ovf, a_cnt, a_acc,
                            b_out_valid, b_in_ready, b_busy, b_ovf, b_cnt, b_acc};

    add2_accum #(.N_SAMPLES(N), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .sum(sum), .cout(cout),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
        .acc_out(a_acc), .ovf(a_ovf), .busy(a_busy), .sample_cnt(a_cnt)
    );

    add2_accum #(.N_SAMPLES(N), .ACC_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .sum(sum), .cout(cout),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
        .acc_out(b_acc), .ovf(b_ovf), .busy(b_busy), .sample_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int t, input int mx);
        return (t > mx) ? mx : t;
    endfunction

    task automatic update_exp();
        exp_vec = {m_phase == 2, m_phase == 1, m_phase != 0, m_total > 255, 4'(m_cnt), 8'(sat(m_total, 255)),
                   m_phase == 2, m_phase == 1, m_phase != 0, m_total > 15,  4'(m_cnt), 4'(sat(m_total, 15))};
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_total = 0;
        m_cnt   = 0;
        update_exp();
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic cycle(input logic st, input logic iv, input logic [2:0] v, input logic ordy);
        start     = st;
        in_valid  = iv;
        {cout, sum} = v;
        out_ready = ordy;
        @(posedge clk);
        #1;
        case (m_phase)
            0: if (st) begin
                m_phase = 1;
                m_total = 0;
                m_cnt   = 0;
            end
            1: if (iv) begin
                m_total = m_total + int'(v);
                m_cnt   = m_cnt + 1;
                if (m_cnt == N) m_phase = 2;
            end
            default: if (ordy) m_phase = 0;
        endcase
        update_exp();
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; sum = 2'd0; cout = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        n_cmp++; if (dut_vec !== 28'd0) begin n_mis++; $display("FAIL reset_async: got %h want %h", dut_vec, 28'd0); end
        @(posedge clk);
        #1;
        n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL reset_edge: got %h want %h", dut_vec, exp_vec); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        n_cmp++; if ({a_in_ready, a_busy, a_cnt, a_acc} !== {1'b1, 1'b1, 4'd0, 8'd0}) begin
            n_mis++; $display("FAIL basic_start: got rdy=%b busy=%b cnt=%0d acc=%0d want 1 1 0 0", a_in_ready, a_busy, a_cnt, a_acc);
        end
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, 3'd1, 1'b0);
            n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL basic[%0d]: got %h want %h", i, dut_vec, exp_vec); end
        end
        n_cmp++; if ({a_out_valid, a_ovf, a_acc} !== {1'b1, 1'b0, 8'd8}) begin
            n_mis++; $display("FAIL basic_total: got ov=%b ovf=%b acc=%0d want 1 0 8", a_out_valid, a_ovf, a_acc);
        end
        cycle(1'b0, 1'b0, 3'd0, 1'b1);
        n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL basic_idle: got %h want %h", dut_vec, exp_vec); end
    endtask

    task automatic test_saturate();
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, 3'd4, 1'b0);
            n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL sat[%0d]: got %h want %h", i, dut_vec, exp_vec); end
            n_cmp++; if ({b_ovf, b_acc} !== {i >= 3, (i >= 3) ? 4'd15 : 4'(4 * (i + 1))}) begin
                n_mis++; $display("FAIL sat4[%0d]: got ovf=%b acc=%0d", i, b_ovf, b_acc);
            end
        end
        n_cmp++; if ({b_out_valid, b_cnt, a_acc} !== {1'b1, 4'd8, 8'd32}) begin
            n_mis++; $display("FAIL sat_done: got ov=%b cnt=%0d acc8=%0d want 1 8 32", b_out_valid, b_cnt, a_acc);
        end
        cycle(1'b0, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_gaps();
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, (i % 2) == 0, 3'd2, 1'b0);
            n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL gaps[%0d]: got %h want %h", i, dut_vec, exp_vec); end
            n_cmp++; if (a_cnt !== 4'(i / 2 + 1)) begin n_mis++; $display("FAIL gaps_cnt[%0d]: got %0d want %0d", i, a_cnt, i / 2 + 1); end
        end
        n_cmp++; if ({a_out_valid, a_acc} !== {1'b1, 8'd16}) begin
            n_mis++; $display("FAIL gaps_total: got ov=%b acc=%0d want 1 16", a_out_valid, a_acc);
        end
    endtask

    task automatic test_done_hold();
        for (int i = 0; i < 5; i++) begin
            cycle(1'((i % 2) == 0), 1'b1, 3'd7, 1'b0);
            n_cmp++; if ({a_out_valid, a_in_ready, a_cnt, a_acc} !== {1'b1, 1'b0, 4'd8, 8'd16}) begin
                n_mis++; $display("FAIL hold[%0d]: got ov=%b rdy=%b cnt=%0d acc=%0d want 1 0 8 16", i, a_out_valid, a_in_ready, a_cnt, a_acc);
            end
        end
        cycle(1'b0, 1'b0, 3'd0, 1'b1);
        n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL hold_release: got %h want %h", dut_vec, exp_vec); end
        cycle(1'b0, 1'b1, 3'd7, 1'b0);
        n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL idle_ignore: got %h want %h", dut_vec, exp_vec); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 3'($urandom_range(1, 7)), 1'b0);
        n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL mid_pre: got %h want %h", dut_vec, exp_vec); end
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (dut_vec !== 28'd0) begin n_mis++; $display("FAIL mid_rst: got %h want %h", dut_vec, 28'd0); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, 3'd7, 1'b0);
            n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL mid_run[%0d]: got %h want %h", i, dut_vec, exp_vec); end
        end
        n_cmp++; if ({a_acc, b_acc, b_ovf} !== {8'd56, 4'd15, 1'b1}) begin
            n_mis++; $display("FAIL mid_total: got acc8=%0d acc4=%0d ovf4=%b want 56 15 1", a_acc, b_acc, b_ovf);
        end
        cycle(1'b0, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int run = 0; run < 2; run++) begin
            cycle(1'b1, 1'b0, 3'd0, 1'b0);
            n_cmp++; if ({a_busy, a_cnt, a_acc, a_ovf} !== {1'b1, 4'd0, 8'd0, 1'b0}) begin
                n_mis++; $display("FAIL b2b_clear[%0d]: got busy=%b cnt=%0d acc=%0d ovf=%b", run, a_busy, a_cnt, a_acc, a_ovf);
            end
            for (int i = 0; i < N; i++) begin
                cycle(1'b0, 1'b1, 3'($urandom), 1'b0);
                n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL b2b[%0d.%0d]: got %h want %h", run, i, dut_vec, exp_vec); end
            end
            cycle(1'b0, 1'b0, 3'd0, 1'b1);
            n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL b2b_idle[%0d]: got %h want %h", run, dut_vec, exp_vec); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0), 3'($urandom), 1'($urandom_range(0, 1)));
            n_cmp++; if (dut_vec !== exp_vec) begin n_mis++; $display("FAIL rand[%0d]: got %h want %h", i, dut_vec, exp_vec); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_gaps();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
